// File: rtl/wb_dest_queue_pkg.sv
// Shared encodings for the writeback destination queue: selector codes and default widths.
package wb_dest_queue_pkg;

  localparam logic [1:0] SRC_RT  = 2'd0;
  localparam logic [1:0] SRC_RD  = 2'd1;
  localparam logic [1:0] SRC_ALT = 2'd2;
  localparam logic [1:0] SRC_RA  = 2'd3;

  localparam int         DEF_ADDR_W  = 5;
  localparam logic [4:0] DEF_RA_ADDR = 5'h1f;

endpackage

// File: rtl/wb_dest_queue_dest_select.sv
// Four-way register-file destination mux: rt, rd slice of offset, alternate, return address.
module dest_select
  import wb_dest_queue_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                RD_LSB  = 11,
  parameter logic [ADDR_W-1:0] RA_ADDR = {ADDR_W{1'b1}}
) (
  input  logic [1:0]        selector,
  input  logic [ADDR_W-1:0] input_one,
  input  logic [15:0]       offset,
  input  logic [ADDR_W-1:0] input_three,
  output logic [ADDR_W-1:0] dest
);

  always_comb begin
    dest = input_one;
    case (selector)
      SRC_RT:  dest = input_one;
      SRC_RD:  dest = offset[RD_LSB +: ADDR_W];
      SRC_ALT: dest = input_three;
      SRC_RA:  dest = RA_ADDR;
      default: dest = input_one;
    endcase
  end

endmodule

// File: rtl/wb_dest_queue.sv
// In-order queue of pending register writes for multicycle units, with writeback port
// and read-after-write hazard detection against the outstanding destinations.
module wb_dest_queue
  import wb_dest_queue_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter int                DEPTH   = 4,
  parameter int                RD_LSB  = 11,
  parameter logic [ADDR_W-1:0] RA_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               selector,
  input  logic [ADDR_W-1:0]        input_one,
  input  logic [15:0]              offset,
  input  logic [ADDR_W-1:0]        input_three,
  input  logic                     issue,
  output logic                     issue_ready,
  input  logic                     complete,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        chk_a,
  input  logic [ADDR_W-1:0]        chk_b,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic                     wb_valid,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]             dest;
  logic [DEPTH-1:0][ADDR_W-1:0]  q_addr;
  logic [DEPTH-1:0]              q_wen;
  logic [DEPTH-1:0]              q_vld;
  logic [PTR_W-1:0]              head, tail;
  logic [CNT_W-1:0]              cnt;
  logic                          push, pop;
  logic [DEPTH-1:0]              hit_a, hit_b;

  dest_select #(
    .ADDR_W  (ADDR_W),
    .RD_LSB  (RD_LSB),
    .RA_ADDR (RA_ADDR)
  ) u_dest_select (
    .selector    (selector),
    .input_one   (input_one),
    .offset      (offset),
    .input_three (input_three),
    .dest        (dest)
  );

  assign full        = (cnt == CNT_W'(DEPTH));
  assign empty       = (cnt == '0);
  assign issue_ready = !full;
  assign count       = cnt;

  // Acceptance looks only at pre-edge occupancy: a pop never frees room for a same-cycle push.
  assign push = issue && !full && !flush;
  assign pop  = complete && !empty && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_addr    <= '0;
      q_wen     <= '0;
      q_vld     <= '0;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      q_vld    <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      wb_valid <= 1'b0;
    end else begin
      if (push) begin
        q_addr[tail] <= dest;
        q_wen[tail]  <= (dest != '0);
        q_vld[tail]  <= 1'b1;
        tail         <= tail + 1'b1;
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= head + 1'b1;
        wb_addr     <= q_addr[head];
        wb_valid    <= q_wen[head];
      end else begin
        wb_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (complete && empty)
        underflow <= 1'b1;
    end
  end

  // Hazard comparators see stored entries only; register 0 is never a real dependency.
  for (genvar i = 0; i < DEPTH; i++) begin : g_haz
    assign hit_a[i] = q_vld[i] && q_wen[i] && (q_addr[i] == chk_a);
    assign hit_b[i] = q_vld[i] && q_wen[i] && (q_addr[i] == chk_b);
  end

  assign hazard_a = (|hit_a) && (chk_a != '0);
  assign hazard_b = (|hit_b) && (chk_b != '0);

endmodule
